// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states and the keyboard command
// and response bytes used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  localparam logic [7:0] RESP_ACK     = 8'hFA;
  localparam logic [7:0] RESP_RESEND  = 8'hFE;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for one open-drain PS/2 line.
// The flops reset to 1 because an idle, released PS/2 line is pulled high.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset_L,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic meta;
  logic sync_prev;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      meta      <= 1'b1;
      sync      <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      meta      <= pin;
      sync      <= meta;
      sync_prev <= sync;
    end
  end

  assign fall = sync_prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus, clocks one command byte
// out on device-generated clock edges and reports the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       STOP_EDGE_IDX = 4'd9;

  state_t           state;
  state_t           state_next;
  logic [8:0]       shreg;
  logic [3:0]       edge_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             drive_low;
  logic             acked;
  logic             clk_sync;
  logic             clk_fall;
  logic             data_sync;
  logic             data_fall_unused;
  logic             timing;
  logic             timed_out;

  ps2_sync_edge u_clk_sync (
    .clock   (clock),
    .reset_L (reset_L),
    .pin     (ps2_clk_in),
    .sync    (clk_sync),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clock   (clock),
    .reset_L (reset_L),
    .pin     (ps2_data_in),
    .sync    (data_sync),
    .fall    (data_fall_unused)
  );

  // The watchdog covers everything after the clock line is handed to the device.
  assign timing    = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign timed_out = timing && (to_cnt == TO_LIMIT);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shreg     <= '0;
      edge_cnt  <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      drive_low <= 1'b0;
      acked     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) shreg <= {odd_parity(tx_data), tx_data};
          inh_cnt <= '0;
        end
        INHIBIT: if (inh_cnt != INH_LAST) inh_cnt <= inh_cnt + 1'b1;
        START: begin
          drive_low <= 1'b1;  // start bit stays on the line until the first falling edge
          edge_cnt  <= '0;
          to_cnt    <= '0;
          acked     <= 1'b0;
        end
        SHIFT: begin
          if (clk_fall) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == STOP_EDGE_IDX) begin
              drive_low <= 1'b0;
            end else begin
              drive_low <= ~shreg[0];
              shreg     <= {1'b0, shreg[8:1]};
            end
          end
        end
        ACK: if (clk_fall) acked <= ~data_sync;
        default: ;
      endcase
      if (timing && (to_cnt != TO_LIMIT)) to_cnt <= to_cnt + 1'b1;
    end
  end

  // NOTE: each combinational block assigns a default to every output first,
  // so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (tx_valid) state_next = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) state_next = START;
      START:     state_next = SHIFT;
      SHIFT:     if (clk_fall && (edge_cnt == STOP_EDGE_IDX)) state_next = ACK;
      ACK:       if (clk_fall) state_next = WAIT_IDLE;
      WAIT_IDLE: if (clk_sync && data_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timed_out) state_next = IDLE;
  end

  always_comb begin
    tx_ready    = (state == IDLE);
    ps2_clk_oe  = (state == INHIBIT) || (state == START);
    ps2_data_oe = (state == START) || ((state == SHIFT) && drive_low && !timed_out);
    done        = timed_out || ((state == WAIT_IDLE) && clk_sync && data_sync);
    ack_ok      = done && !timed_out && acked;
    err_timeout = timed_out;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: serializes one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the PS/2 host-request protocol.
- Reports whether the device acknowledged the byte.
- Sits beside the keyboard receiver that feeds scan codes to the display/Enigma datapath; drives the shared open-drain ps2 clock/data lines through output-enable pins.

Parameters:
- INHIBIT_CYCLES, 5000, clocks the host holds ps2 clock low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clocks from clock release to ack sample before abort (15 ms at 50 MHz).

Ports:
- clock  input  1  system clock
- reset_L  input  1  asynchronous active-low reset
- tx_data  input  8  command byte
- tx_valid  input  1  request; accepted when tx_valid && tx_ready
- tx_ready  output  1  high only in IDLE
- ps2_clk_in  input  1  raw ps2 clock pin (asynchronous)
- ps2_data_in  input  1  raw ps2 data pin (asynchronous)
- ps2_clk_oe  output  1  1 = pull ps2 clock low; 0 = release
- ps2_data_oe  output  1  1 = pull ps2 data low; 0 = release
- done  output  1  one-cycle pulse at end of every accepted transfer
- ack_ok  output  1  valid with done: 1 = device acked
- err_timeout  output  1  valid with done: 1 = transfer aborted by timeout

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (reset_L).
- Reset values: tx_ready=1, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, err_timeout=0; state IDLE; counters 0.
- Reset asserted mid-transfer: both lines released immediately (asynchronously); no done pulse.
- Synchronization: ps2 pins pass through a 2-flop synchronizer; a falling edge is sync_prev=1 && sync=0. Any line response must occur within 4 clocks of the pin edge.
- Accept: tx_valid && tx_ready latches tx_data and odd parity (~^tx_data) into a 9-bit shift register [parity, d7..d0]. Next cycle: INHIBIT, tx_ready=0.
- Accept while the device is mid-transmit (clock toggling): still allowed. Inhibit aborts the device frame per protocol.
- States:
  - IDLE: lines released.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES.
  - START: data_oe=1 and clk_oe=1 for 1 cycle, then clk_oe=0 and start timeout counter; go to SHIFT. The device samples the start bit on its first rising edge.
  - SHIFT: on each ps2 clock falling edge, present the next bit: data_oe = ~bit, LSB first, 9 edges (d0..d7, parity). On the 10th falling edge, data_oe=0 (stop bit = 1); go to ACK.
  - ACK: on the next falling edge, sample synchronized data. 0 = ack_ok=1, else ack_ok=0. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse done and go to IDLE. tx_ready returns 1 the cycle after done.
- Timeout: counter runs from clock release through WAIT_IDLE. Reaching TIMEOUT_CYCLES in any of these states:
  - release both lines;
  - done=1, err_timeout=1, ack_ok=0;
  - go to IDLE.
- Counter widths are $clog2(param+1). Counters saturate, never wrap.
- tx_valid during busy is ignored; no queuing.
- Missing device clock edges can only end in timeout, never a hang.

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE;
  - command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE;
  - device response constants: RESP_ACK=8'hFA, RESP_RESEND=8'hFE.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detector for one line. Instantiated for clock and data here and reused by the keyboard receiver.

Test Plan:
- Normal send: tx_data=0xED, device BFM clocks at 12.5 kHz and acks.
  - Line sees start=0, bits 1,0,1,1,0,1,1,1, parity 1 (0xED has six ones), stop=1.
  - done pulse with ack_ok=1, err_timeout=0; tx_ready=1 next cycle.
- Parity/data check: tx_data=0x00.
  - Parity bit = 1, and INHIBIT clk_oe low duration is exactly INHIBIT_CYCLES (5000 at default; use INHIBIT_CYCLES=10 in sim).
  - Then tx_data=0xFF: parity = 1.
- No ack: BFM leaves data high at the ack edge → done, ack_ok=0, err_timeout=0.
- Dead device: BFM never clocks, TIMEOUT_CYCLES=200.
  - 200 cycles after clock release: both oe=0, done=1, err_timeout=1; back to IDLE.
- Busy and reset: second tx_valid during SHIFT is ignored (exactly one frame on the line).
  - reset_L pulsed low mid-SHIFT: clk_oe and data_oe go 0 with no clock edge, no done; tx_ready=1 after release.
